direction_scheduler: RTL and testbench
======================================

# direction_scheduler

Sequences snake movement from decoded keyboard events. Accepts one-cycle key events (released-key scan codes) from the keyboard front end, buffers direction requests in a small FIFO, and applies at most one per game step on an internally generated step tick. Also owns pause/resume and game reset, and filters illegal 180° reversals, so downstream game logic sees only a clean direction and a step strobe.

## Interface
- QUEUE_DEPTH, 4: direction FIFO entries; power of 2, ≥2.
- TICK_DIV, 25_000_000: clk cycles per game step; ≥2.
- clk  in  1  system clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- key_valid  in  1  one-cycle strobe: key_code holds a completed released-key scan code.
- key_code  in  8  scan code; 8'h1D up, 8'h1C left, 8'h1B down, 8'h23 right, 8'h5A enter (game reset), 8'h29 space (pause toggle); all others ignored.
- direction  out  5  one-hot: 5'b00001 idle, 5'b00010 up, 5'b00100 left, 5'b01000 down, 5'b10000 right.
- step  out  1  one-cycle pulse per game step.
- game_reset  out  1  one-cycle pulse after enter.
- paused  out  1  high while in PAUSED.
- queue_count  out  $clog2(QUEUE_DEPTH)+1  FIFO occupancy.
- overflow  out  1  one-cycle pulse when a direction request is dropped because the FIFO is full.

## Operation
- Reset (async, reset_n low): direction=5'b00001, step=0, game_reset=0, paused=0, queue_count=0, overflow=0, state IDLE, tick counter 0, FIFO empty.
- States: IDLE, RUN, PAUSED.
- IDLE: counter held at 0, no step. A direction key loads direction directly (no FIFO), goes to RUN, counter starts at 0. Space ignored.
- RUN: counter increments 0..TICK_DIV-1, wraps to 0. On the wrap cycle: step pulses and one FIFO entry is popped if non-empty.
- Popped entry that is the reverse of the current direction (up↔down, left↔right) is discarded; direction unchanged; no second pop that step. Otherwise direction takes the popped value.
- Space in RUN → PAUSED; space in PAUSED → RUN. PAUSED holds counter value, emits no step, pops nothing; direction keys still enqueue.
- Enter from any state: game_reset pulse, FIFO flushed, direction=5'b00001, counter=0, paused=0, state IDLE. Enter wins over any same-cycle pop.
- Enqueue (RUN/PAUSED, direction key): dropped without overflow if equal to the last enqueued entry (FIFO non-empty) or to current direction (FIFO empty). Dropped with overflow pulse if full and no pop that cycle.
- Simultaneous push and pop: both performed; full+pop+push accepts push, count unchanged. Empty+pop+push: no bypass; pop finds empty, push enqueued, count=1. Dedupe on empty-and-popping compares against current direction before update.
- FIFO entries stored as 2-bit codes; read/write pointers wrap modulo QUEUE_DEPTH.

## Timing
- All outputs registered. key_valid at edge N → direction (IDLE load), paused, game_reset, overflow, queue_count updated after edge N.
- Step: counter reaches TICK_DIV-1 at edge N; step and new direction both visible after edge N+1 for exactly one cycle (step) — direction and step change together.
- Step period exactly TICK_DIV cycles in uninterrupted RUN; a pause of P cycles delays the next step by exactly P cycles.
- key_valid one cycle wide; back-to-back strobes on consecutive cycles all processed.
- game_reset high exactly one cycle; a key in the cycle after enter is processed in IDLE.
- reset_n assertion mid-step clears all outputs immediately, including an active step pulse.

## Test plan
- Reset with TICK_DIV=4: direction=00001, step never pulses for 20 cycles; key 8'h1D → direction=00010 next cycle, step every 4 cycles thereafter.
- In RUN(up): enqueue left, down, right → queue_count=3; next three steps give left, down, right in order; queue_count 2,1,0.
- Reversal: RUN(up), enqueue down then left → first step keeps up (down discarded), second step gives left.
- Overflow/dedupe with QUEUE_DEPTH=4: enqueue left twice → count=1; fill to 4, fifth distinct key → overflow one cycle, count=4; push on pop cycle while full → accepted, count stays 4.
- Pause: space in RUN → paused=1, no steps for 50 cycles, key enqueued; space → paused=0, next step after remaining counter cycles.
- Enter with FIFO at 3 coinciding with a step: game_reset one cycle, direction=00001, queue_count=0, state IDLE; mid-run reset_n low → all outputs at reset values asynchronously.

Source files
------------

// File: rtl/direction_scheduler.sv
// rtl/direction_scheduler.sv - snake direction sequencer: key decode, direction FIFO, step tick, pause/reset FSM
module direction_scheduler #(
    parameter int QUEUE_DEPTH = 4,
    parameter int TICK_DIV    = 25_000_000
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         key_valid,
    input  logic [7:0]                   key_code,
    output logic [4:0]                   direction,
    output logic                         step,
    output logic                         game_reset,
    output logic                         paused,
    output logic [$clog2(QUEUE_DEPTH):0] queue_count,
    output logic                         overflow
);
    localparam int AW = $clog2(QUEUE_DEPTH);
    localparam int QW = AW + 1;
    localparam int CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] TICK_MAX = CW'(TICK_DIV - 1);
    localparam logic [QW-1:0] FULL     = QW'(QUEUE_DEPTH);
    localparam logic [4:0]    DIR_IDLE = 5'b00001;

    typedef enum logic [1:0] {IDLE, RUN, PAUSED} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [4:0]      dir_q, dir_d;
    logic [AW-1:0]   wr_q, wr_d, rd_q, rd_d;
    logic [QW-1:0]   count_q, count_d;
    logic            step_q, step_d, grst_q, grst_d, ovf_q, ovf_d;
    logic [1:0]      mem_q [QUEUE_DEPTH];

    logic            is_dir, is_enter, is_space, push, pop, wrap, dup;
    logic [1:0]      key_dir, popped, last;

    // Codes: 0 up, 1 left, 2 down, 3 right; the reverse of a code is code ^ 2.
    function automatic logic [4:0] to_onehot(input logic [1:0] c);
        return 5'b00010 << c;
    endfunction

    always_comb begin
        is_dir  = key_valid;
        key_dir = 2'd0;
        case (key_code)
            8'h1D:   key_dir = 2'd0;
            8'h1C:   key_dir = 2'd1;
            8'h1B:   key_dir = 2'd2;
            8'h23:   key_dir = 2'd3;
            default: is_dir  = 1'b0;
        endcase
    end

    assign is_enter = key_valid && (key_code == 8'h5A);
    assign is_space = key_valid && (key_code == 8'h29);
    assign wrap     = (state_q == RUN) && (cnt_q == TICK_MAX);
    assign popped   = mem_q[rd_q];
    assign last     = mem_q[wr_q - 1'b1];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q;
        step_d  = 1'b0;
        grst_d  = 1'b0;
        ovf_d   = 1'b0;
        push    = 1'b0;
        pop     = 1'b0;
        dup     = 1'b0;
        if (is_enter) begin
            state_d = IDLE;
            cnt_d   = '0;
            dir_d   = DIR_IDLE;
            wr_d    = '0;
            rd_d    = '0;
            count_d = '0;
            grst_d  = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (is_dir) begin
                        dir_d   = to_onehot(key_dir);
                        state_d = RUN;
                        cnt_d   = '0;
                    end
                end
                RUN: begin
                    cnt_d = wrap ? '0 : cnt_q + 1'b1;
                    if (is_space) state_d = PAUSED;
                    if (wrap) begin
                        step_d = 1'b1;
                        if (count_q != '0) begin
                            pop = 1'b1;
                            if (to_onehot(popped ^ 2'd2) != dir_q) dir_d = to_onehot(popped);
                        end
                    end
                end
                PAUSED: begin
                    if (is_space) state_d = RUN;
                end
                default: state_d = IDLE;
            endcase
            // Dedupe looks at the newest queued entry, or the live direction when the queue is empty.
            if (state_q != IDLE && is_dir) begin
                dup = (count_q != '0) ? (key_dir == last) : (to_onehot(key_dir) == dir_q);
                if (!dup) begin
                    if (count_q == FULL && !pop) ovf_d = 1'b1;
                    else                         push  = 1'b1;
                end
            end
            if (push) wr_d = wr_q + 1'b1;
            if (pop)  rd_d = rd_q + 1'b1;
            count_d = count_q + QW'(push) - QW'(pop);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dir_q   <= DIR_IDLE;
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            step_q  <= 1'b0;
            grst_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
            step_q  <= step_d;
            grst_q  <= grst_d;
            ovf_q   <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= key_dir;
    end

    assign direction   = dir_q;
    assign step        = step_q;
    assign game_reset  = grst_q;
    assign paused      = (state_q == PAUSED);
    assign queue_count = count_q;
    assign overflow    = ovf_q;
endmodule

// File: tb/tb_direction_scheduler.sv
// tb/tb_direction_scheduler.sv - directed table and sequence checks for direction_scheduler
module tb_direction_scheduler;
    localparam logic [7:0] K_UP = 8'h1D, K_LEFT = 8'h1C, K_DOWN = 8'h1B, K_RIGHT = 8'h23;
    localparam logic [7:0] K_ENTER = 8'h5A, K_SPACE = 8'h29, K_NONE = 8'h00;
    localparam logic [4:0] D_IDLE = 5'b00001, D_UP = 5'b00010, D_LEFT = 5'b00100;
    localparam logic [4:0] D_DOWN = 5'b01000, D_RIGHT = 5'b10000;

    logic       clk = 1'b0;
    logic       reset_n, key_valid;
    logic [7:0] key_code;
    logic [4:0] direction;
    logic       step, game_reset, paused, overflow;
    logic [2:0] queue_count;

    int total = 0;
    int bad   = 0;

    direction_scheduler #(.QUEUE_DEPTH(4), .TICK_DIV(4)) dut (
        .clk(clk), .reset_n(reset_n), .key_valid(key_valid), .key_code(key_code),
        .direction(direction), .step(step), .game_reset(game_reset), .paused(paused),
        .queue_count(queue_count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] code;
        logic [4:0] dir;
        logic [2:0] cnt;
        logic       ovf;
        logic       psd;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic press(input logic [7:0] c);
        key_valid = 1'b1;
        key_code  = c;
        @(negedge clk);
        key_valid = 1'b0;
        key_code  = K_NONE;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_step(input int n, input string name);
        int early = 0;
        for (int i = 0; i < n - 1; i++) begin
            @(negedge clk);
            if (step) early++;
        end
        chk({name, "_early"}, early, 0);
        @(negedge clk);
        chk(name, step, 1);
    endtask

    task automatic chk_reset_vals(input string name);
        chk({name, "_dir"}, direction, D_IDLE);
        chk({name, "_step"}, step, 0);
        chk({name, "_grst"}, game_reset, 0);
        chk({name, "_paused"}, paused, 0);
        chk({name, "_count"}, queue_count, 0);
        chk({name, "_ovf"}, overflow, 0);
    endtask

    initial begin
        int n;
        vecs[0]  = '{K_SPACE, D_IDLE, 3'd0, 1'b0, 1'b0};
        vecs[1]  = '{K_NONE,  D_IDLE, 3'd0, 1'b0, 1'b0};
        vecs[2]  = '{K_UP,    D_UP,   3'd0, 1'b0, 1'b0};
        vecs[3]  = '{K_SPACE, D_UP,   3'd0, 1'b0, 1'b1};
        vecs[4]  = '{K_UP,    D_UP,   3'd0, 1'b0, 1'b1};
        vecs[5]  = '{K_LEFT,  D_UP,   3'd1, 1'b0, 1'b1};
        vecs[6]  = '{K_LEFT,  D_UP,   3'd1, 1'b0, 1'b1};
        vecs[7]  = '{K_DOWN,  D_UP,   3'd2, 1'b0, 1'b1};
        vecs[8]  = '{K_RIGHT, D_UP,   3'd3, 1'b0, 1'b1};
        vecs[9]  = '{K_UP,    D_UP,   3'd4, 1'b0, 1'b1};
        vecs[10] = '{K_LEFT,  D_UP,   3'd4, 1'b1, 1'b1};
        vecs[11] = '{K_NONE,  D_UP,   3'd4, 1'b0, 1'b1};
        vecs[12] = '{K_UP,    D_UP,   3'd4, 1'b0, 1'b1};
        vecs[13] = '{K_SPACE, D_UP,   3'd4, 1'b0, 1'b0};

        reset_n   = 1'b0;
        key_valid = 1'b0;
        key_code  = K_NONE;
        idle(2);
        chk_reset_vals("rst");
        reset_n = 1'b1;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (step) n++;
        end
        chk("idle_nostep", n, 0);
        chk("idle_dir", direction, D_IDLE);

        for (int i = 0; i < 14; i++) begin
            press(vecs[i].code);
            chk($sformatf("vec%0d_dir", i), direction, vecs[i].dir);
            chk($sformatf("vec%0d_count", i), queue_count, vecs[i].cnt);
            chk($sformatf("vec%0d_ovf", i), overflow, vecs[i].ovf);
            chk($sformatf("vec%0d_paused", i), paused, vecs[i].psd);
        end

        expect_step(3, "order1");
        chk("order1_dir", direction, D_LEFT);
        chk("order1_count", queue_count, 3);
        expect_step(4, "order2");
        chk("order2_dir", direction, D_DOWN);
        chk("order2_count", queue_count, 2);
        expect_step(4, "order3");
        chk("order3_dir", direction, D_RIGHT);
        chk("order3_count", queue_count, 1);
        expect_step(4, "order4");
        chk("order4_dir", direction, D_UP);
        chk("order4_count", queue_count, 0);

        press(K_DOWN);
        press(K_LEFT);
        chk("rev_count", queue_count, 2);
        expect_step(2, "rev1");
        chk("rev1_dir", direction, D_UP);
        chk("rev1_count", queue_count, 1);
        expect_step(4, "rev2");
        chk("rev2_dir", direction, D_LEFT);

        press(K_SPACE);
        press(K_UP);
        press(K_DOWN);
        press(K_UP);
        press(K_RIGHT);
        chk("fill_count", queue_count, 4);
        press(K_SPACE);
        idle(2);
        chk("fill_prestep", step, 0);
        press(K_LEFT);
        chk("fullpop_step", step, 1);
        chk("fullpop_count", queue_count, 4);
        chk("fullpop_ovf", overflow, 0);
        chk("fullpop_dir", direction, D_UP);

        expect_step(4, "rev3");
        chk("rev3_dir", direction, D_UP);
        chk("rev3_count", queue_count, 3);
        idle(3);
        press(K_ENTER);
        chk("enter_grst", game_reset, 1);
        chk("enter_dir", direction, D_IDLE);
        chk("enter_count", queue_count, 0);
        chk("enter_paused", paused, 0);
        chk("enter_step", step, 0);
        press(K_RIGHT);
        chk("after_enter_grst", game_reset, 0);
        chk("after_enter_dir", direction, D_RIGHT);
        expect_step(4, "after_enter_step");

        press(K_ENTER);
        press(K_UP);
        press(K_SPACE);
        press(K_LEFT);
        chk("pause_enq", queue_count, 1);
        n = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (step || !paused) n++;
        end
        chk("pause_hold", n, 0);
        press(K_SPACE);
        chk("resume_paused", paused, 0);
        expect_step(3, "resume_step");
        chk("resume_dir", direction, D_LEFT);
        chk("resume_count", queue_count, 0);

        press(K_UP);
        press(K_RIGHT);
        n = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (step) begin
                n = 1;
                break;
            end
        end
        chk("async_found_step", n, 1);
        chk("async_pre_count", queue_count, 1);
        reset_n = 1'b0;
        #1;
        chk_reset_vals("async");
        @(negedge clk);
        reset_n = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
